// File: rtl/reg_shift_sequencer_pkg.sv
//------------------------------------------------------------------------------
// reg_shift_sequencer_pkg : shift codes and FSM states shared with Val2 logic
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reg_shift_sequencer_pkg;

  localparam int C_DEF_WIDTH     = 32;
  localparam int C_DEF_STEP_LOG2 = 3;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RS_READ = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_shift_sequencer_step.sv
//------------------------------------------------------------------------------
// shift_step_unit : combinational shift of one value by k (0..2**STEP_LOG2)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_step_unit
  import reg_shift_sequencer_pkg::*;
#(
  parameter int WIDTH     = C_DEF_WIDTH,
  parameter int STEP_LOG2 = C_DEF_STEP_LOG2
) (
  input  logic [WIDTH-1:0]   i_value,
  input  shift_t             i_type,
  input  logic [STEP_LOG2:0] i_k,
  output logic [WIDTH-1:0]   o_value,
  output logic               o_last
);

  // One guard bit beyond the word catches the last bit shifted out.
  logic [WIDTH:0]     w_lsl;
  logic [WIDTH:0]     w_lsr;
  logic [WIDTH:0]     w_asr;
  logic [2*WIDTH-1:0] w_ror;

  always_comb begin
    w_lsl   = {1'b0, i_value} << i_k;
    w_lsr   = {i_value, 1'b0} >> i_k;
    w_asr   = (WIDTH+1)'($signed({i_value, 1'b0}) >>> i_k);
    w_ror   = {i_value, i_value} >> i_k;
    o_value = i_value;
    o_last  = 1'b0;
    case (i_type)
      SH_LSL: begin
        o_value = w_lsl[WIDTH-1:0];
        o_last  = w_lsl[WIDTH];
      end
      SH_LSR: begin
        o_value = w_lsr[WIDTH:1];
        o_last  = w_lsr[0];
      end
      SH_ASR: begin
        o_value = w_asr[WIDTH:1];
        o_last  = w_asr[0];
      end
      default: begin
        o_value = w_ror[WIDTH-1:0];
        o_last  = w_ror[WIDTH-1];
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reg_shift_sequencer.sv
//------------------------------------------------------------------------------
// reg_shift_sequencer : multi-cycle register-shifted-register Val2 sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_shift_sequencer
  import reg_shift_sequencer_pkg::*;
#(
  parameter int WIDTH     = C_DEF_WIDTH,
  parameter int STEP_LOG2 = C_DEF_STEP_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic             o_start_ready,
  input  logic [11:0]      i_shift_operand,
  input  logic [WIDTH-1:0] i_val_rm,
  input  logic             i_carry_in,
  output logic             o_rs_req,
  input  logic             i_rs_gnt,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic             i_flush,
  output logic             o_done,
  input  logic             i_done_ready,
  output logic [WIDTH-1:0] o_val_out,
  output logic             o_c_out,
  output logic             o_stall
);

  localparam int C_STEP  = 2 ** STEP_LOG2;
  localparam int C_CNT_W = $clog2(WIDTH + 2);
  localparam int C_LOG_W = $clog2(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  shift_t               r_type;
  logic [WIDTH-1:0]     r_val;
  logic                 r_c;
  logic [C_CNT_W-1:0]   r_rem;
  logic [C_CNT_W-1:0]   w_n;
  logic [C_CNT_W-1:0]   w_rem_nxt;
  logic [STEP_LOG2:0]   w_k;
  logic [7:0]           w_amt;
  logic [WIDTH-1:0]     w_step_val;
  logic                 w_step_last;
  logic                 w_unused_bits;

  assign w_unused_bits = ^{i_shift_operand[11:7], i_shift_operand[4:0], i_rs_data[WIDTH-1:8]};
  assign w_amt         = i_rs_data[7:0];

  // Clamp the raw amount so iterative shifting reproduces ARM edge cases.
  always_comb begin
    w_n = '0;
    case (r_type)
      SH_LSL, SH_LSR:
        w_n = (w_amt > 8'(WIDTH + 1)) ? C_CNT_W'(WIDTH + 1) : C_CNT_W'(w_amt);
      SH_ASR:
        w_n = (w_amt > 8'(WIDTH)) ? C_CNT_W'(WIDTH) : C_CNT_W'(w_amt);
      default: begin
        if (w_amt[C_LOG_W-1:0] == '0)
          w_n = (w_amt != 8'd0) ? C_CNT_W'(WIDTH) : '0;
        else
          w_n = C_CNT_W'(w_amt[C_LOG_W-1:0]);
      end
    endcase
  end

  always_comb begin
    if (r_rem > C_CNT_W'(C_STEP))
      w_k = (STEP_LOG2 + 1)'(C_STEP);
    else
      w_k = r_rem[STEP_LOG2:0];
    w_rem_nxt = r_rem - C_CNT_W'(w_k);
  end

  shift_step_unit #(
    .WIDTH     (WIDTH),
    .STEP_LOG2 (STEP_LOG2)
  ) u_step (
    .i_value (r_val),
    .i_type  (r_type),
    .i_k     (w_k),
    .o_value (w_step_val),
    .o_last  (w_step_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_start_ready = (r_state == S_IDLE);
    o_rs_req      = (r_state == S_RS_READ);
    o_done        = (r_state == S_DONE);
    o_stall       = (r_state != S_IDLE) && !((r_state == S_DONE) && i_done_ready);
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_start) w_state_nxt = S_RS_READ;
        S_RS_READ: if (i_rs_gnt) w_state_nxt = (w_n == '0) ? S_DONE : S_SHIFT;
        S_SHIFT:   if (w_rem_nxt == '0) w_state_nxt = S_DONE;
        default:   if (i_done_ready) w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Rm/carry are loaded on accept so a zero count finishes with no SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type <= SH_LSL;
      r_val  <= '0;
      r_c    <= 1'b0;
      r_rem  <= '0;
    end else if (!i_flush) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_type <= shift_t'(i_shift_operand[6:5]);
            r_val  <= i_val_rm;
            r_c    <= i_carry_in;
          end
        end
        S_RS_READ: begin
          if (i_rs_gnt) r_rem <= w_n;
        end
        S_SHIFT: begin
          r_val <= w_step_val;
          r_c   <= w_step_last;
          r_rem <= w_rem_nxt;
        end
        default: ;
      endcase
    end
  end

  assign o_val_out = r_val;
  assign o_c_out   = r_c;

endmodule

`default_nettype wire
